// File: rtl/mmio_mul_pkg.sv
// Shared definitions for the mmio_mul_chain accelerator: register offsets,
// STATUS/CTRL bit positions, accumulator type, FSM states and a byte-lane helper.
package mmio_mul_pkg;

  localparam logic [7:0] OFF_OPERAND = 8'h00;
  localparam logic [7:0] OFF_CTRL    = 8'h80;
  localparam logic [7:0] OFF_STATUS  = 8'h84;
  localparam logic [7:0] OFF_RES_LO  = 8'h88;
  localparam logic [7:0] OFF_RES_HI  = 8'h8C;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_OVF_BIT  = 2;
  localparam int CTRL_START_BIT  = 31;

  typedef logic [63:0] acc_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } seq_state_t;

  // Replace only the byte lanes selected by strb.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mul_64x32.sv
// Iterative shift-add multiplier: 64-bit a times 32-bit b, one multiplier bit
// per cycle. The product and done pulse appear combinationally during the 32nd
// cycle after start so the caller can chain the next step on the same edge.
// Optional macro MMIO_MUL_OVF_EN widens the partial product to 96 bits and
// exposes an ovf flag for products that do not fit in 64 bits.
module seq_mul_64x32
  import mmio_mul_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  acc_t        a,
  input  logic [31:0] b,
  output acc_t        product,
  output logic        done
`ifdef MMIO_MUL_OVF_EN
  ,
  output logic        ovf
`endif
);

`ifdef MMIO_MUL_OVF_EN
  localparam int PW = 96;
`else
  localparam int PW = 64;
`endif

  logic [PW-1:0] a_sh;
  logic [PW-1:0] part;
  logic [PW-1:0] part_next;
  logic [31:0]   b_sh;
  logic [5:0]    cnt;
  logic          active;

  // Partial product after adding the current multiplicand row.
  always_comb begin
    part_next = part + (b_sh[0] ? a_sh : '0);
  end

  assign product = part_next[63:0];
  assign done    = active && (cnt == 6'd1);

`ifdef MMIO_MUL_OVF_EN
  assign ovf = |part_next[PW-1:64];
`endif

  // Shift-add iteration; a new start reloads the operands even mid-run.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_sh   <= '0;
      b_sh   <= '0;
      part   <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      a_sh   <= PW'(a);
      b_sh   <= b;
      part   <= '0;
      cnt    <= 6'd32;
      active <= 1'b1;
    end else if (active) begin
      part <= part_next;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt - 6'd1;
      if (cnt == 6'd1) active <= 1'b0;
    end
  end

endmodule

// File: rtl/mmio_mul_chain.sv
// Memory-mapped product-chain accelerator on a PicoRV32-style mem bus.
// Holds N operands, multiplies operand[0..k-1] modulo 2^64 using the
// sequential multiplier, and reports busy/done/ovf plus a completion pulse.
// Optional macro MMIO_MUL_OVF_EN enables the sticky overflow flag.
module mmio_mul_chain
  import mmio_mul_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0100_3000,
  parameter int          N         = 8,
  parameter int          CNT_W     = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done_irq
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [31:0]      operand [N];
  logic [31:0]      ctrl_reg;
  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] k_reg;
  acc_t             acc;
  acc_t             result;
  logic             done_flag;
  logic             ovf_flag;
  logic             launch;
  seq_state_t       state;
  seq_state_t       state_next;

  logic             in_window;
  logic [7:0]       offset;
  logic [4:0]       word_idx;
  logic [IDX_W-1:0] op_sel;
  logic             op_hit;
  logic             accept;
  logic             is_write;
  logic [31:0]      ctrl_merged;
  logic [CNT_W-1:0] count_in;
  logic [CNT_W-1:0] k_eff;
  logic             start_cmd;
  logic [31:0]      rd_value;
  logic             unused_addr_bits;

  logic             mul_start;
  acc_t             mul_a;
  logic [31:0]      mul_b;
  logic [CNT_W-1:0] b_idx;
  acc_t             mul_product;
  logic             mul_done;
  logic             mul_ovf;
  logic             finish;
  acc_t             fin_val;

  assign in_window        = (mem_addr[31:8] == ADDR_BASE[31:8]);
  assign offset           = mem_addr[7:0];
  assign word_idx         = offset[6:2];
  assign op_sel           = word_idx[IDX_W-1:0];
  assign op_hit           = (offset[7] == 1'b0) && (32'(word_idx) < N);
  assign unused_addr_bits = ^mem_addr[1:0];
  assign accept           = mem_valid && !mem_ready && in_window;
  assign is_write         = |mem_wstrb;
  assign busy             = (state == ST_RUN);

  assign ctrl_merged = merge_bytes(ctrl_reg, mem_wdata, mem_wstrb);
  assign count_in    = ctrl_merged[CNT_W-1:0];
  assign k_eff       = (count_in > CNT_W'(N)) ? CNT_W'(N) : count_in;
  assign start_cmd   = accept && (offset == OFF_CTRL) && mem_wstrb[3] &&
                       mem_wdata[CTRL_START_BIT] && (state == ST_IDLE);

  assign mul_b = operand[b_idx[IDX_W-1:0]];

  seq_mul_64x32 u_mul (
    .clk     (clk),
    .resetn  (resetn),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .product (mul_product),
    .done    (mul_done)
`ifdef MMIO_MUL_OVF_EN
    ,
    .ovf     (mul_ovf)
`endif
  );

`ifndef MMIO_MUL_OVF_EN
  assign mul_ovf = 1'b0;
`endif

  // Register read mux; unmapped offsets inside the window read as zero.
  always_comb begin
    rd_value = '0;
    if (op_hit) begin
      rd_value = operand[op_sel];
    end else begin
      case (offset)
        OFF_STATUS: begin
          rd_value[STATUS_BUSY_BIT] = busy;
          rd_value[STATUS_DONE_BIT] = done_flag;
          rd_value[STATUS_OVF_BIT]  = ovf_flag;
        end
        OFF_RES_LO: rd_value = result[31:0];
        OFF_RES_HI: rd_value = result[63:32];
        default:    rd_value = '0;
      endcase
    end
  end

  // One-cycle bus acknowledge with read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= (accept && !is_write) ? rd_value : '0;
    end
  end

  // Operand and CTRL count storage; operand writes are dropped while running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) operand[i] <= '0;
      ctrl_reg <= '0;
    end else if (accept && is_write) begin
      if (op_hit && (state == ST_IDLE)) begin
        operand[op_sel] <= merge_bytes(operand[op_sel], mem_wdata, mem_wstrb);
      end
      if (offset == OFF_CTRL) begin
        ctrl_reg <= {{(32-CNT_W){1'b0}}, count_in};
      end
    end
  end

  // Sequencing FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next state and multiplier launch; the first step waits one cycle after START.
  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    mul_a      = acc;
    b_idx      = step;
    finish     = 1'b0;
    fin_val    = acc;
    case (state)
      ST_IDLE: begin
        if (start_cmd && (k_eff != '0)) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (launch) begin
          if (k_reg == CNT_W'(1)) begin
            finish     = 1'b1;
            state_next = ST_IDLE;
          end else begin
            mul_start = 1'b1;
          end
        end else if (mul_done) begin
          if (step == k_reg - CNT_W'(1)) begin
            finish     = 1'b1;
            fin_val    = mul_product;
            state_next = ST_IDLE;
          end else begin
            mul_start = 1'b1;
            mul_a     = mul_product;
            b_idx     = step + CNT_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Accumulator, step counter, result and status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc       <= '0;
      result    <= '0;
      step      <= '0;
      k_reg     <= '0;
      launch    <= 1'b0;
      done_flag <= 1'b0;
      ovf_flag  <= 1'b0;
      done_irq  <= 1'b0;
    end else begin
      done_irq <= finish;
      if (start_cmd) begin
        done_flag <= 1'b0;
        ovf_flag  <= 1'b0;
        if (k_eff == '0) begin
          result    <= 64'd1;
          done_flag <= 1'b1;
          done_irq  <= 1'b1;
        end else begin
          acc    <= {32'd0, operand[0]};
          step   <= CNT_W'(1);
          k_reg  <= k_eff;
          launch <= 1'b1;
        end
      end else if (state == ST_RUN) begin
        launch <= 1'b0;
        if (mul_done && !launch) begin
          ovf_flag <= ovf_flag | mul_ovf;
          if (!finish) begin
            acc  <= mul_product;
            step <= step + CNT_W'(1);
          end
        end
        if (finish) begin
          result    <= fin_val;
          done_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_mul_chain.sv
// Directed self-checking bench for mmio_mul_chain.
module tb_mmio_mul_chain;

  localparam logic [31:0] BASE = 32'h0100_3000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done_irq;

  int checks = 0;
  int errors = 0;
  int irq_count = 0;

`ifdef MMIO_MUL_OVF_EN
  localparam logic [63:0] OVF_EXP = 64'd1;
`else
  localparam logic [63:0] OVF_EXP = 64'd0;
`endif

  mmio_mul_chain #(.ADDR_BASE(BASE), .N(8), .CNT_W(6)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done_irq  (done_irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done_irq === 1'b1) irq_count++;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_access(input logic [7:0] off, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata);
    @(negedge clk);
    if (mem_ready) @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE + {24'd0, off};
    mem_wdata = wdata;
    mem_wstrb = strb;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    check_output("bus_ready", {63'd0, mem_ready}, 64'd1);
    rdata = mem_rdata;
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] dummy;
    bus_access(off, data, strb, dummy);
  endtask

  task automatic check_read(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    bus_access(off, 32'd0, 4'h0, rd);
    check_output(tag, {32'd0, rd}, {32'd0, exp});
  endtask

  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 2000) begin
      cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cyc;
    int base_irq;
    int seen;

    resetn    = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    #3 resetn = 1'b0;
    #5;
    check_output("rst_ready", {63'd0, mem_ready}, 64'd0);
    check_output("rst_rdata", {32'd0, mem_rdata}, 64'd0);
    check_output("rst_busy", {63'd0, busy}, 64'd0);
    check_output("rst_irq", {63'd0, done_irq}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check_read("rst_status", 8'h84, 32'd0);

    // 3*5*7 over three operands.
    bus_write(8'h00, 32'd3, 4'hF);
    bus_write(8'h04, 32'd5, 4'hF);
    bus_write(8'h08, 32'd7, 4'hF);
    base_irq = irq_count;
    bus_write(8'h80, 32'h8000_0003, 4'hF);
    wait_busy(cyc);
    check_output("busy_k3", 64'(cyc), 64'd65);
    check_output("irq_at_done", {63'd0, done_irq}, 64'd1);
    check_read("res_lo_105", 8'h88, 32'd105);
    check_read("res_hi_105", 8'h8C, 32'd0);
    check_read("status_done", 8'h84, 32'h2);
    check_output("irq_once", 64'(irq_count - base_irq), 64'd1);

    // Full-width operands, then a step that overflows 64 bits.
    bus_write(8'h00, 32'hFFFF_FFFF, 4'hF);
    bus_write(8'h04, 32'hFFFF_FFFF, 4'hF);
    bus_write(8'h80, 32'h8000_0002, 4'hF);
    wait_busy(cyc);
    check_output("busy_k2", 64'(cyc), 64'd33);
    check_read("sq_lo", 8'h88, 32'h0000_0001);
    check_read("sq_hi", 8'h8C, 32'hFFFF_FFFE);
    check_read("sq_status", 8'h84, 32'h2);
    bus_write(8'h08, 32'h10, 4'hF);
    bus_write(8'h80, 32'h8000_0003, 4'hF);
    wait_busy(cyc);
    check_read("ovf_lo", 8'h88, 32'h0000_0010);
    check_read("ovf_hi", 8'h8C, 32'hFFFF_FFE0);
    check_read("ovf_status", 8'h84, 32'h2 | 32'(OVF_EXP << 2));

    // Count zero: result 1 without busy.
    bus_write(8'h80, 32'h8000_0000, 4'hF);
    check_output("k0_busy", {63'd0, busy}, 64'd0);
    check_output("k0_irq", {63'd0, done_irq}, 64'd1);
    check_read("k0_lo", 8'h88, 32'd1);
    check_read("k0_hi", 8'h8C, 32'd0);
    check_read("k0_status", 8'h84, 32'h2);

    // Count 40 clamps to 8: 8! = 40320.
    for (int i = 0; i < 8; i++) bus_write(8'(4 * i), 32'(i + 1), 4'hF);
    bus_write(8'h80, 32'h8000_0028, 4'hF);
    wait_busy(cyc);
    check_output("busy_clamp", 64'(cyc), 64'd225);
    check_read("clamp_lo", 8'h88, 32'h0000_9D80);

    // Operand write and second START while busy are ignored.
    bus_write(8'h00, 32'd3, 4'hF);
    bus_write(8'h04, 32'd5, 4'hF);
    bus_write(8'h08, 32'd7, 4'hF);
    base_irq = irq_count;
    bus_write(8'h80, 32'h8000_0003, 4'hF);
    check_read("hold_lo", 8'h88, 32'h0000_9D80);
    bus_write(8'h04, 32'd100, 4'hF);
    bus_write(8'h80, 32'h8000_0001, 4'hF);
    check_read("drop_op1", 8'h04, 32'd5);
    wait_busy(cyc);
    check_read("busy_ign_lo", 8'h88, 32'd105);
    check_output("busy_ign_irq", 64'(irq_count - base_irq), 64'd1);

    // Unmapped offsets and byte-lane writes.
    check_read("unmapped_90", 8'h90, 32'd0);
    bus_write(8'h20, 32'hDEAD_BEEF, 4'hF);
    check_read("operand_n", 8'h20, 32'd0);
    bus_write(8'h00, 32'h1234_5678, 4'hF);
    bus_write(8'h00, 32'hAABB_CCDD, 4'h1);
    check_read("wstrb_b0", 8'h00, 32'h1234_56DD);

    // Outside the window: no response.
    @(negedge clk);
    @(negedge clk);
    seen = 0;
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h100;
    mem_wstrb = 4'h0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (mem_ready === 1'b1) seen++;
    end
    mem_valid = 1'b0;
    check_output("outside_noack", 64'(seen), 64'd0);

    // Asynchronous reset mid-computation.
    bus_write(8'h00, 32'd3, 4'hF);
    bus_write(8'h80, 32'h8000_0003, 4'hF);
    repeat (10) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check_output("arst_busy", {63'd0, busy}, 64'd0);
    check_output("arst_ready", {63'd0, mem_ready}, 64'd0);
    check_output("arst_irq", {63'd0, done_irq}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check_read("arst_status", 8'h84, 32'd0);
    check_read("arst_lo", 8'h88, 32'd0);
    check_read("arst_hi", 8'h8C, 32'd0);
    check_read("arst_op0", 8'h00, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
